// File: rtl/flag_branch_pkg.sv
// Shared types for the flag register and branch-condition evaluation.
// Optional same-cycle flag forwarding is enabled with FLAG_FWD_EN.
package flag_branch_pkg;

    typedef enum logic [2:0] {
        NE  = 3'b000,
        EQ  = 3'b001,
        GT  = 3'b010,
        LT  = 3'b011,
        GE  = 3'b100,
        LE  = 3'b101,
        OV  = 3'b110,
        UNC = 3'b111
    } br_cond_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    localparam int     RST_PC    = 0;
    localparam flags_t FLAGS_RST = '{z: 1'b0, v: 1'b0, n: 1'b0};

endpackage

// File: rtl/br_cond_eval.sv
// Pure combinational condition check; shared with the decode-side predictor.
// Maps a condition code and a flag set to a taken decision.
module br_cond_eval
    import flag_branch_pkg::*;
(
    input  flags_t   flg,
    input  br_cond_e cond,
    output logic     taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            NE:      taken = !flg.z;
            EQ:      taken = flg.z;
            GT:      taken = !flg.z && !flg.n;
            LT:      taken = flg.n;
            GE:      taken = flg.z || !flg.n;
            LE:      taken = flg.z || flg.n;
            OV:      taken = flg.v;
            UNC:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register, branch resolution and one-entry target register.
// Define FLAG_FWD_EN to forward same-cycle ALU flags into branch evaluation.
module flag_branch_unit
    import flag_branch_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       flag_we,
    input  logic             zero,
    input  logic             ovfl,
    input  logic             sign,
    input  logic             flush,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc_inc,
    input  logic [OFF_W-1:0] br_off,
    output logic             tgt_valid,
    input  logic             tgt_ready,
    output logic [PC_W-1:0]  tgt_pc,
    output logic             tgt_taken,
    output logic [2:0]       flags
);

    flags_t          flag_q;
    flags_t          flag_eval;
    logic            taken;
    logic            accept;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= FLAGS_RST;
        end else begin
            if (flag_we[2]) flag_q.z <= zero;
            if (flag_we[1]) flag_q.v <= ovfl;
            if (flag_we[0]) flag_q.n <= sign;
        end
    end

    always_comb begin
        flag_eval = flag_q;
`ifdef FLAG_FWD_EN
        if (flag_we[2]) flag_eval.z = zero;
        if (flag_we[1]) flag_eval.v = ovfl;
        if (flag_we[0]) flag_eval.n = sign;
`endif
    end

    br_cond_eval u_eval (
        .flg   (flag_eval),
        .cond  (br_cond_e'(br_cond)),
        .taken (taken)
    );

    // Word offset: sign-extend and scale by two in one concatenation.
    assign off_ext = {{(PC_W-OFF_W-1){br_off[OFF_W-1]}}, br_off, 1'b0};
    assign pc_next = taken ? br_pc_inc + off_ext : br_pc_inc;

    assign br_ready = !tgt_valid || tgt_ready;
    assign accept   = br_valid && br_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_valid <= 1'b0;
            tgt_pc    <= PC_W'(RST_PC);
            tgt_taken <= 1'b0;
        end else if (flush) begin
            tgt_valid <= 1'b0;
        end else if (accept) begin
            tgt_valid <= 1'b1;
            tgt_pc    <= pc_next;
            tgt_taken <= taken;
        end else if (tgt_ready) begin
            tgt_valid <= 1'b0;
        end
    end

    assign flags = flag_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench: driver models branch resolution, monitor checks outputs.
// Expectations follow FLAG_FWD_EN when the build defines it.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flag_we;
    logic        zero, ovfl, sign, flush;
    logic        br_valid, br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc_inc;
    logic [8:0]  br_off;
    logic        tgt_valid, tgt_ready, tgt_taken;
    logic [15:0] tgt_pc;
    logic [2:0]  flags;

    typedef struct {
        logic [15:0] pc;
        logic        tk;
    } exp_t;

    exp_t q[$];
    bit   m_valid;
    bit   mz, mv, mn;
    int   checks = 0;
    int   errors = 0;

    flag_branch_unit #(.PC_W(16), .OFF_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_we   (flag_we),
        .zero      (zero),
        .ovfl      (ovfl),
        .sign      (sign),
        .flush     (flush),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_pc_inc (br_pc_inc),
        .br_off    (br_off),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_pc    (tgt_pc),
        .tgt_taken (tgt_taken),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit cond_taken(input int c, input bit z,
                                      input bit v, input bit n);
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return z || n;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        mz = 0;
        mv = 0;
        mn = 0;
    endtask

    task automatic model_edge();
        bit   z, v, n, acc, tk;
        int   tp;
        exp_t e;
        if (!rst_n) return;
        z = mz;
        v = mv;
        n = mn;
`ifdef FLAG_FWD_EN
        if (flag_we[2]) z = zero;
        if (flag_we[1]) v = ovfl;
        if (flag_we[0]) n = sign;
`endif
        acc = br_valid && (!m_valid || tgt_ready);
        if (flush && m_valid && !tgt_ready && q.size() > 0)
            void'(q.pop_front());
        if (acc && !flush) begin
            tk = cond_taken(int'(br_cond), z, v, n);
            tp = int'(br_pc_inc);
            if (tk) tp = tp + 2 * int'($signed(br_off));
            e.pc = tp[15:0];
            e.tk = tk;
            q.push_back(e);
        end
        if (flush)          m_valid = 0;
        else if (acc)       m_valid = 1;
        else if (tgt_ready) m_valid = 0;
        if (flag_we[2]) mz = zero;
        if (flag_we[1]) mv = ovfl;
        if (flag_we[0]) mn = sign;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        flag_we  = 3'b000;
        br_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic branch(input logic [2:0] c, input logic [15:0] pc,
                          input logic [8:0] off);
        br_valid  = 1'b1;
        br_cond   = c;
        br_pc_inc = pc;
        br_off    = off;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tgt_valid", 32'(tgt_valid), 32'd0);
            chk("rst_tgt_pc", 32'(tgt_pc), 32'd0);
            chk("rst_tgt_taken", 32'(tgt_taken), 32'd0);
            chk("rst_flags", 32'(flags), 32'd0);
            chk("rst_br_ready", 32'(br_ready), 32'd1);
        end else begin
            chk("tgt_valid", 32'(tgt_valid), 32'(m_valid));
            chk("br_ready", 32'(br_ready), 32'(!m_valid || tgt_ready));
            chk("flags", 32'(flags), 32'({mz, mv, mn}));
            if (tgt_valid) begin
                if (q.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("tgt_pc", 32'(tgt_pc), 32'(q[0].pc));
                    chk("tgt_taken", 32'(tgt_taken), 32'(q[0].tk));
                    if (tgt_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        zero = 0; ovfl = 0; sign = 0;
        br_cond = 3'd0; br_pc_inc = 16'h0; br_off = 9'h0;
        tgt_ready = 1'b1;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset dropped while a target is held under backpressure.
        tgt_ready = 1'b0;
        flag_we = 3'b111; zero = 1; ovfl = 1; sign = 1;
        branch(3'd7, 16'h1234, 9'd8);
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tgt_ready = 1'b1;
        tick();

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                idle();
                flag_we = 3'b111;
                zero = f[2]; ovfl = f[1]; sign = f[0];
                tick();
                idle();
                branch(3'(c), 16'h0100, 9'd4);
                tick();
            end
        end
        idle();
        tick();

        branch(3'd7, 16'hFFFE, 9'd1);
        tick();
        branch(3'd7, 16'h0002, 9'h1FE);
        tick();
        branch(3'd7, 16'h0200, 9'h100);
        tick();
        idle();
        tick();

        tgt_ready = 1'b0;
        branch(3'd7, 16'h4000, 9'd3);
        repeat (4) tick();
        branch(3'd7, 16'h5000, 9'd5);
        tgt_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            branch(3'd7, 16'(16'h6000 + i * 16), 9'(i));
            tick();
        end
        idle();
        tick();

        // Flag write and EQ branch in the same cycle.
        flag_we = 3'b111; zero = 0; ovfl = 0; sign = 0;
        tick();
        idle();
        flag_we = 3'b100; zero = 1;
        branch(3'd1, 16'h0100, 9'd4);
        tick();
        idle();
        tick();

        flag_we = 3'b011; ovfl = 1; sign = 1;
        branch(3'd7, 16'h0800, 9'd2);
        flush = 1'b1;
        tick();
        idle();
        tick();
        tgt_ready = 1'b0;
        branch(3'd7, 16'h0900, 9'd2);
        tick();
        idle();
        flush = 1'b1;
        tick();
        idle();
        tgt_ready = 1'b1;
        tick();

        for (int i = 0; i < 2000; i++) begin
            flag_we   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            zero      = 1'($urandom);
            ovfl      = 1'($urandom);
            sign      = 1'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            br_valid  = ($urandom_range(0, 3) != 0);
            br_cond   = 3'($urandom);
            br_pc_inc = 16'($urandom) & 16'hFFFE;
            br_off    = 9'($urandom);
            tgt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        tgt_ready = 1'b1;
        repeat (3) tick();
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
